// File: rtl/m_cluster_mem_arbiter_pkg.sv
// m_cluster_mem_arbiter_pkg: shared defines for the cluster memory arbiter
package m_cluster_mem_arbiter_pkg;
   localparam logic [1:0] PRIV_U = 2'd0;
   localparam logic [1:0] PRIV_S = 2'd1;
   localparam logic [1:0] PRIV_M = 2'd3;
   localparam int PRIO_RR    = 0;
   localparam int PRIO_FIXED = 1;
   typedef enum logic {ST_IDLE, ST_OWN} arb_state_e;
endpackage

// File: rtl/m_cluster_mem_arbiter_if.sv
// m_cluster_mem_arbiter_if: hart request bus and arbiter grant/ownership outputs
interface m_cluster_mem_arbiter_if #(
   parameter int N_HARTS = 2,
   parameter int AW      = 32
);
   localparam int SW = $clog2(N_HARTS + 1);
   logic [N_HARTS-1:0]    w_req;
   logic [N_HARTS-1:0]    w_lock;
   logic [N_HARTS*AW-1:0] w_addr;
   logic                  w_busy;
   logic [N_HARTS-1:0]    r_grant;
   logic [SW-1:0]         r_sel;
   logic                  r_valid;
   logic [AW-1:0]         w_out_addr;
   logic [N_HARTS-1:0]    w_core_busy;
   modport master (
      output w_req, w_lock, w_addr, w_busy,
      input  r_grant, r_sel, r_valid, w_out_addr, w_core_busy
   );
   modport slave (
      input  w_req, w_lock, w_addr, w_busy,
      output r_grant, r_sel, r_valid, w_out_addr, w_core_busy
   );
endinterface

// File: rtl/m_cluster_mem_arbiter_rr_pick.sv
// m_rr_pick: first set request from a start index with wrap, or lowest index in fixed mode
module m_rr_pick #(
   parameter int N  = 2,
   parameter int SW = $clog2(N + 1)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] start,
   input  logic          mode,
   output logic [SW-1:0] idx,
   output logic          found
);
   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   assign dbl = {req, req} >> start;
   assign rot = mode ? req : dbl[N-1:0];
   // scan the rotated vector; bit i of rot is hart (start+i) mod N in round-robin mode
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!found && rot[i]) begin
            found = 1'b1;
            idx   = mode ? SW'(i) : ((int'(start) + i >= N) ? SW'(int'(start) + i - N) : SW'(int'(start) + i));
         end
      end
   end
endmodule

// File: rtl/m_cluster_mem_arbiter.sv
// m_cluster_mem_arbiter: grants one hart ownership of the memory port with hold/lock control
module m_cluster_mem_arbiter
   import m_cluster_mem_arbiter_pkg::*;
#(
   parameter int N_HARTS   = 2,
   parameter int AW        = 32,
   parameter int PRIO_MODE = 0,
   parameter int MAX_HOLD  = 0
) (
   input logic CLK,
   input logic RST_X,
   m_cluster_mem_arbiter_if.slave bus
);
   localparam int SW = $clog2(N_HARTS + 1);
   localparam int HW = $clog2(MAX_HOLD + 2);
   arb_state_e         state_q, state_d;
   logic [N_HARTS-1:0] grant_q, grant_d, pick_req;
   logic [SW-1:0]      sel_q, sel_d, last_q, last_d, start, pick_idx;
   logic [HW-1:0]      hold_q, hold_d;
   logic [AW-1:0]      out_addr;
   logic               own, rel, pick_found;
   assign own      = state_q == ST_OWN;
   assign pick_req = own ? bus.w_req & ~grant_q : bus.w_req;
   assign start    = (last_q >= SW'(N_HARTS - 1)) ? '0 : last_q + 1'b1;
   assign rel      = !bus.w_busy && !(|(bus.w_lock & grant_q)) &&
                     (!(|(bus.w_req & grant_q)) || (MAX_HOLD > 0 && hold_q >= HW'(MAX_HOLD) && |pick_req));
   m_rr_pick #(.N(N_HARTS), .SW(SW)) u_pick (
      .req   (pick_req),
      .start (start),
      .mode  (PRIO_MODE == PRIO_FIXED),
      .idx   (pick_idx),
      .found (pick_found)
   );
   // state, owner, last-owner and hold-count registers
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         sel_q   <= '0;
         last_q  <= SW'(N_HARTS - 1);
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
      end
   end
   // grant from IDLE, or hand over on release with the current owner masked out
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      last_d  = last_q;
      hold_d  = (own && hold_q < HW'(MAX_HOLD)) ? hold_q + 1'b1 : hold_q;
      if (!own || rel) begin
         if (pick_found) begin
            state_d = ST_OWN;
            grant_d = N_HARTS'(1) << pick_idx;
            sel_d   = pick_idx;
            last_d  = pick_idx;
            hold_d  = '0;
         end else if (own) begin
            state_d = ST_IDLE;
            grant_d = '0;
            hold_d  = '0;
         end
      end
   end
   // owner address mux; grant is all zero in IDLE so the result is zero there
   always_comb begin
      out_addr = '0;
      for (int g = 0; g < N_HARTS; g++) out_addr = out_addr | ({AW{grant_q[g]}} & bus.w_addr[g*AW +: AW]);
   end
   assign bus.r_grant     = grant_q;
   assign bus.r_sel       = sel_q;
   assign bus.r_valid     = own;
   assign bus.w_out_addr  = out_addr;
   assign bus.w_core_busy = ~grant_q | {N_HARTS{bus.w_busy}};
endmodule

// File: tb/tb_m_cluster_mem_arbiter.sv
// tb_m_cluster_mem_arbiter: directed scoreboard bench over RR, fixed-priority and hold-limit arbiters
module tb_m_cluster_mem_arbiter;
   typedef struct {
      string       tag;
      logic [3:0]  grant;
      logic [2:0]  sel;
      logic        valid;
      logic [31:0] addr;
   } exp_t;
   logic CLK = 1'b0;
   logic RST_X;
   int   n_chk = 0;
   int   n_err = 0;
   int   prev, nx;
   exp_t sb[$];
   m_cluster_mem_arbiter_if #(.N_HARTS(4), .AW(32)) if_rr ();
   m_cluster_mem_arbiter_if #(.N_HARTS(4), .AW(32)) if_fx ();
   m_cluster_mem_arbiter_if #(.N_HARTS(4), .AW(32)) if_mh ();
   m_cluster_mem_arbiter #(.N_HARTS(4), .AW(32), .PRIO_MODE(0), .MAX_HOLD(0)) u_rr (.CLK(CLK), .RST_X(RST_X), .bus(if_rr.slave));
   m_cluster_mem_arbiter #(.N_HARTS(4), .AW(32), .PRIO_MODE(1), .MAX_HOLD(0)) u_fx (.CLK(CLK), .RST_X(RST_X), .bus(if_fx.slave));
   m_cluster_mem_arbiter #(.N_HARTS(4), .AW(32), .PRIO_MODE(0), .MAX_HOLD(3)) u_mh (.CLK(CLK), .RST_X(RST_X), .bus(if_mh.slave));
   always #5 CLK = ~CLK;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic push(input string tag, input int idx);
      exp_t e;
      e.tag   = tag;
      e.valid = idx >= 0;
      e.grant = idx >= 0 ? 4'(1 << idx) : 4'b0;
      e.sel   = idx >= 0 ? 3'(idx) : 3'd0;
      e.addr  = idx >= 0 ? 32'hA000_0000 + 32'(idx) : 32'h0;
      sb.push_back(e);
   endtask
   task automatic sb_pop(input logic [3:0] g, input logic [2:0] s, input logic v, input logic [31:0] a);
      exp_t e;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'(sb.size()), 32'd1);
      end else begin
         e = sb.pop_front();
         chk({e.tag, ".grant"}, 32'(g), 32'(e.grant));
         chk({e.tag, ".sel"}, 32'(s), 32'(e.sel));
         chk({e.tag, ".valid"}, 32'(v), 32'(e.valid));
         chk({e.tag, ".addr"}, a, e.addr);
      end
   endtask
   task automatic obs_rr();
      sb_pop(if_rr.r_grant, if_rr.r_sel, if_rr.r_valid, if_rr.w_out_addr);
   endtask
   task automatic obs_fx();
      sb_pop(if_fx.r_grant, if_fx.r_sel, if_fx.r_valid, if_fx.w_out_addr);
   endtask
   task automatic obs_mh();
      sb_pop(if_mh.r_grant, if_mh.r_sel, if_mh.r_valid, if_mh.w_out_addr);
   endtask
   initial begin
      RST_X = 1'b0;
      if_rr.w_req = '0; if_rr.w_lock = '0; if_rr.w_busy = 1'b0;
      if_fx.w_req = '0; if_fx.w_lock = '0; if_fx.w_busy = 1'b0;
      if_mh.w_req = '0; if_mh.w_lock = '0; if_mh.w_busy = 1'b0;
      for (int g = 0; g < 4; g++) begin
         if_rr.w_addr[g*32 +: 32] = 32'hA000_0000 + 32'(g);
         if_fx.w_addr[g*32 +: 32] = 32'hA000_0000 + 32'(g);
         if_mh.w_addr[g*32 +: 32] = 32'hA000_0000 + 32'(g);
      end
      repeat (2) @(negedge CLK);
      push("rst_rr", -1); obs_rr();
      push("rst_fx", -1); obs_fx();
      push("rst_mh", -1); obs_mh();
      chk("rst_core_busy_rr", 32'(if_rr.w_core_busy), 32'hF);
      chk("rst_core_busy_mh", 32'(if_mh.w_core_busy), 32'hF);
      RST_X = 1'b1;
      // round-robin rotation with no bubble
      if_rr.w_req = 4'b1111;
      push("rr_first", 0); @(negedge CLK); obs_rr();
      push("rr_hold", 0); @(negedge CLK); obs_rr();
      chk("rr_core_busy_idle_bus", 32'(if_rr.w_core_busy), 32'hE);
      prev = 0;
      for (int k = 1; k <= 4; k++) begin
         nx = k % 4;
         if_rr.w_req = 4'b1111 & ~(4'b0001 << prev);
         push($sformatf("rr_next%0d", k), nx); @(negedge CLK); obs_rr();
         prev = nx;
      end
      // owner drops request while the controller is busy
      if_rr.w_req  = 4'b1110;
      if_rr.w_busy = 1'b1;
      for (int k = 0; k < 2; k++) begin
         push("rr_busy_keep", 0); @(negedge CLK); obs_rr();
         chk("rr_core_busy_busy", 32'(if_rr.w_core_busy), 32'hF);
      end
      if_rr.w_busy = 1'b0;
      push("rr_busy_done", 1); @(negedge CLK); obs_rr();
      chk("rr_core_busy_own1", 32'(if_rr.w_core_busy), 32'hD);
      // fixed priority
      if_fx.w_req = 4'b1010; push("fx_a", 1); @(negedge CLK); obs_fx();
      if_fx.w_req = 4'b1000; push("fx_b", 3); @(negedge CLK); obs_fx();
      if_fx.w_req = 4'b0011; push("fx_c", 0); @(negedge CLK); obs_fx();
      if_fx.w_req = 4'b0010; push("fx_d", 1); @(negedge CLK); obs_fx();
      if_fx.w_req = 4'b1001; push("fx_e", 0); @(negedge CLK); obs_fx();
      // hold limit forces handover, lock blocks it
      if_mh.w_req = 4'b0011;
      for (int k = 0; k < 4; k++) begin
         push("mh_own0", 0); @(negedge CLK); obs_mh();
      end
      push("mh_force1", 1); @(negedge CLK); obs_mh();
      for (int k = 0; k < 3; k++) begin
         push("mh_own1", 1); @(negedge CLK); obs_mh();
      end
      push("mh_force0", 0); @(negedge CLK); obs_mh();
      if_mh.w_lock = 4'b0001;
      for (int k = 0; k < 6; k++) begin
         push("mh_lock_hold", 0); @(negedge CLK); obs_mh();
      end
      if_mh.w_req = 4'b0010;
      for (int k = 0; k < 2; k++) begin
         push("mh_lock_noreq", 0); @(negedge CLK); obs_mh();
      end
      if_mh.w_lock = 4'b0000;
      push("mh_unlock", 1); @(negedge CLK); obs_mh();
      // asynchronous reset between edges
      @(negedge CLK);
      #2 RST_X = 1'b0;
      #1;
      chk("async_rst_rr_grant", 32'(if_rr.r_grant), 32'h0);
      chk("async_rst_rr_valid", 32'(if_rr.r_valid), 32'h0);
      chk("async_rst_mh_valid", 32'(if_mh.r_valid), 32'h0);
      chk("async_rst_rr_core_busy", 32'(if_rr.w_core_busy), 32'hF);
      @(negedge CLK);
      RST_X = 1'b1;
      if_rr.w_req = 4'b0100;
      push("rr_after_rst", 2); @(negedge CLK); obs_rr();
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
